ahbext_sram_ctrl: RTL and testbench

- AHB-Lite subordinate on the SoC external-memory port. It consumes the manager-side bus and HSELEXT, and returns HRDATAEXT, HREADYEXT and HRESPEXT.
- Bridges AHB transfers to a synchronous single-port SRAM with fixed read latency and byte-enabled writes.
- Inserts read wait states and generates the two-cycle AHB ERROR response for unsupported sizes.

---
 rtl/ahbext_pkg.sv | 20 ++
 rtl/ahbext_waitcnt.sv | 41 ++++
 rtl/ahbext_sram_ctrl.sv | 146 ++++++++++++++
 tb/tb_ahbext_sram_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbext_pkg.sv
// Shared types and AHB encodings for the external-memory SRAM controller.
package ahbext_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    ERR1,
    ERR2
  } statetype_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbext_waitcnt.sv
// Read wait-state counter: cleared on load, counts while enabled, holds at RD_LAT.
module ahbext_waitcnt
  import ahbext_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       en_i,
  output logic [2:0] cnt_o,
  output logic       done_o
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic [2:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise step until the latency is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAT)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == LAT);

endmodule

// File: rtl/ahbext_sram_ctrl.sv
// AHB-Lite subordinate bridging single transfers to a fixed-latency synchronous SRAM.
module ahbext_sram_ctrl
  import ahbext_pkg::*;
#(
  parameter int unsigned PA_BITS       = 34,
  parameter int unsigned AHBW          = 64,
  parameter int unsigned MEM_ADDR_BITS = 20,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSELEXT,
  input  logic [PA_BITS-1:0]       HADDR,
  input  logic [AHBW-1:0]          HWDATA,
  input  logic [AHBW/8-1:0]        HWSTRB,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADY,
  output logic [AHBW-1:0]          HRDATAEXT,
  output logic                     HREADYEXT,
  output logic                     HRESPEXT,
  output logic                     MemEn,
  output logic                     MemWe,
  output logic [MEM_ADDR_BITS-1:0] MemAddr,
  output logic [AHBW-1:0]          MemWData,
  output logic [AHBW/8-1:0]        MemBe,
  input  logic [AHBW-1:0]          MemRData
);

  localparam int unsigned OFF = $clog2(AHBW / 8);

  statetype_t               state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     write_q, write_d;
  logic [2:0]               size_q, size_d;
  logic                     accept;
  logic                     complete;
  logic                     cnt_load;
  logic                     cnt_en;
  logic                     cnt_done;
  logic [2:0]               cnt;
  logic                     unused_bits;

  // Burst type and address bits outside the word index are intentionally ignored.
  assign unused_bits = ^{HBURST, HADDR[PA_BITS-1:MEM_ADDR_BITS+OFF], HADDR[OFF-1:0],
                         write_q, size_q};

  assign accept = HSELEXT && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign cnt_en = (state_q == RD);

  ahbext_waitcnt #(
    .RD_LAT (RD_LAT)
  ) u_waitcnt (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .done_o (cnt_done)
  );

  // Data-phase outputs per state; any completing cycle re-samples the bus so
  // back-to-back transfers start without an idle bubble.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    cnt_load  = 1'b0;
    complete  = 1'b0;
    HREADYEXT = 1'b1;
    HRESPEXT  = HRESP_OKAY;
    HRDATAEXT = '0;
    MemEn     = 1'b0;
    MemWe     = 1'b0;
    MemAddr   = '0;
    MemWData  = '0;
    MemBe     = '0;
    unique case (state_q)
      IDLE: complete = 1'b1;
      WR: begin
        MemEn    = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = addr_q;
        MemWData = HWDATA;
        MemBe    = HWSTRB;
        complete = 1'b1;
      end
      RD: begin
        MemEn   = (cnt == 3'd0);
        MemAddr = addr_q;
        if (cnt_done) begin
          HRDATAEXT = MemRData;
          complete  = 1'b1;
        end else begin
          HREADYEXT = 1'b0;
        end
      end
      ERR1: begin
        HREADYEXT = 1'b0;
        HRESPEXT  = HRESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESPEXT = HRESP_ERROR;
        complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      state_d = IDLE;
      if (accept) begin
        addr_d  = HADDR[MEM_ADDR_BITS+OFF-1:OFF];
        write_d = HWRITE;
        size_d  = HSIZE;
        if (HSIZE > 3'(OFF)) begin
          state_d = ERR1;
        end else if (HWRITE) begin
          state_d = WR;
        end else begin
          state_d  = RD;
          cnt_load = 1'b1;
        end
      end
    end
  end

  // State and latched address-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_ahbext_sram_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT=1 and RD_LAT=2) share one AHB stimulus bus.
module tb_ahbext_sram_ctrl;
  import ahbext_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        inst = 1'b0;
  logic        HSELEXT = 1'b0;
  logic [33:0] HADDR = '0;
  logic [63:0] HWDATA = '0;
  logic [7:0]  HWSTRB = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic        HREADY;

  logic        sel1, sel2;
  logic [63:0] rdata1, rdata2, mwd1, mwd2, mrd1, mrd2;
  logic        rdy1, rdy2, resp1, resp2, en1, en2, we1, we2;
  logic [19:0] maddr1, maddr2;
  logic [7:0]  mbe1, mbe2;

  logic [63:0] rdata, mwd;
  logic        resp, en, we;
  logic [19:0] maddr;
  logic [7:0]  mbe;

  always #5 HCLK = ~HCLK;

  assign sel1   = HSELEXT & ~inst;
  assign sel2   = HSELEXT & inst;
  assign HREADY = inst ? rdy2 : rdy1;
  assign rdata  = inst ? rdata2 : rdata1;
  assign resp   = inst ? resp2 : resp1;
  assign en     = inst ? en2 : en1;
  assign we     = inst ? we2 : we1;
  assign maddr  = inst ? maddr2 : maddr1;
  assign mwd    = inst ? mwd2 : mwd1;
  assign mbe    = inst ? mbe2 : mbe1;

  ahbext_sram_ctrl #(.PA_BITS(34), .AHBW(64), .MEM_ADDR_BITS(20), .RD_LAT(1)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(sel1), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATAEXT(rdata1), .HREADYEXT(rdy1), .HRESPEXT(resp1),
    .MemEn(en1), .MemWe(we1), .MemAddr(maddr1), .MemWData(mwd1), .MemBe(mbe1),
    .MemRData(mrd1));

  ahbext_sram_ctrl #(.PA_BITS(34), .AHBW(64), .MEM_ADDR_BITS(20), .RD_LAT(2)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELEXT(sel2), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATAEXT(rdata2), .HREADYEXT(rdy2), .HRESPEXT(resp2),
    .MemEn(en2), .MemWe(we2), .MemAddr(maddr2), .MemWData(mwd2), .MemBe(mbe2),
    .MemRData(mrd2));

  // SRAM models: read-first, byte-enabled writes, latency 1 and 2.
  logic [63:0] mem [2][16];
  logic [63:0] rp1, rp2a, rp2b;
  always @(posedge HCLK) begin
    if (en1) begin
      rp1 <= mem[0][maddr1[3:0]];
      if (we1) for (int b = 0; b < 8; b++) if (mbe1[b]) mem[0][maddr1[3:0]][b*8 +: 8] <= mwd1[b*8 +: 8];
    end
    if (en2) begin
      rp2a <= mem[1][maddr2[3:0]];
      if (we2) for (int b = 0; b < 8; b++) if (mbe2[b]) mem[1][maddr2[3:0]][b*8 +: 8] <= mwd2[b*8 +: 8];
    end
    rp2b <= rp2a;
  end
  assign mrd1 = rp1;
  assign mrd2 = rp2b;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          waits;
    logic        b2b;
  } rsp_t;
  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } mop_t;

  rsp_t rspq[$];
  mop_t memq[$];
  int   checks = 0;
  int   failures = 0;
  bit   last_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: tracks data phases from bus handshakes and pops the scoreboards.
  bit   in_dp = 1'b0, dp_b2b = 1'b0, done_now;
  int   cyc = 0;
  rsp_t mon_e;
  mop_t mon_m;
  always @(negedge HCLK) begin
    done_now = 1'b0;
    if (!HRESETn) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        cyc++;
        if (HREADY) begin
          done_now = 1'b1;
          in_dp = 1'b0;
          if (rspq.size() == 0) fail_now("rsp_unexpected");
          else begin
            mon_e = rspq.pop_front();
            chk("resp", resp, mon_e.err);
            chk("rdata", rdata, mon_e.data);
            chk("waits", 64'(cyc - 1), 64'(mon_e.waits));
            chk("b2b", dp_b2b, mon_e.b2b);
          end
        end else begin
          chk("wait_rdata", rdata, 64'h0);
          if (rspq.size() != 0) chk("wait_resp", resp, rspq[0].err);
        end
      end
      if (HSELEXT && HTRANS[1] && HREADY) begin
        in_dp = 1'b1;
        cyc = 0;
        dp_b2b = done_now;
      end
      if (en) begin
        if (memq.size() == 0) fail_now("mem_unexpected");
        else begin
          mon_m = memq.pop_front();
          chk("mem_we", we, mon_m.we);
          chk("mem_addr", maddr, mon_m.addr);
          chk("mem_be", mbe, mon_m.be);
          if (mon_m.we) chk("mem_wdata", mwd, mon_m.wdata);
        end
      end
    end
  end

  task automatic issue(input logic [33:0] a, input logic wr, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [63:0] wd,
                       input logic [7:0] st, input logic err, input logic [63:0] exp_data,
                       input int waits, input logic [19:0] exp_maddr);
    rsp_t r;
    mop_t m;
    int   n;
    HSELEXT = 1'b1; HADDR = a; HWRITE = wr; HSIZE = sz; HTRANS = tr; HBURST = bu;
    r.err = err; r.data = exp_data; r.waits = waits; r.b2b = last_busy;
    rspq.push_back(r);
    if (!err) begin
      m.we = wr; m.addr = exp_maddr; m.be = wr ? st : 8'h00; m.wdata = wd;
      memq.push_back(m);
    end
    n = 0;
    do begin @(negedge HCLK); n++; end while (!HREADY && n < 40);
    if (!HREADY) fail_now("accept_timeout");
    @(posedge HCLK); #1;
    HWDATA = wd; HWSTRB = st;
    HSELEXT = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0;
    last_busy = 1'b1;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    do begin @(negedge HCLK); n++; end while (!HREADY && n < 40);
    if (!HREADY) fail_now("idle_timeout");
    @(posedge HCLK); #1;
    last_busy = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) mem[k][j] = 64'hCAFE_0000_0000_0000 + 64'(j);

    // Reset with random bus activity.
    for (int i = 0; i < 5; i++) begin
      @(posedge HCLK); #1;
      HSELEXT = 1'($urandom); HTRANS = 2'($urandom); HWRITE = 1'($urandom);
      HSIZE = 3'($urandom); HADDR = 34'($urandom); inst = 1'($urandom);
      @(negedge HCLK);
      chk("rst_hready1", rdy1, 1'b1); chk("rst_hresp1", resp1, 1'b0); chk("rst_memen1", en1, 1'b0);
      chk("rst_hready2", rdy2, 1'b1); chk("rst_memen2", en2, 1'b0);
    end
    @(posedge HCLK); #1;
    HSELEXT = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; inst = 1'b0;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // RD_LAT=1: write, read back, byte write, read back.
    issue(34'h0_8000_0010, 1, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h1122334455667788, 8'hFF, 0, 64'h0, 0, 20'h2);
    issue(34'h0_8000_0010, 0, 3'd3, HTRANS_NONSEQ, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'h1122334455667788, 1, 20'h2);
    issue(34'h0_8000_0015, 1, 3'd0, HTRANS_NONSEQ, 3'd0, 64'h0000AB0000000000, 8'h20, 0, 64'h0, 0, 20'h2);
    issue(34'h0_8000_0010, 0, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h0, 8'h00, 0, 64'h1122AB4455667788, 1, 20'h2);
    idle_wait();

    // Unsupported size, then a read accepted from the ERR2 cycle.
    issue(34'h100, 0, 3'b100, HTRANS_NONSEQ, 3'd0, 64'h0, 8'h00, 1, 64'h0, 1, 20'h0);
    issue(34'h0, 0, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h0, 8'h00, 0, 64'hCAFE000000000000, 1, 20'h0);
    idle_wait();

    // BUSY while selected: zero-wait OKAY, no SRAM activity.
    HSELEXT = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 34'h10; HWRITE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("busy_hready", HREADY, 1'b1); chk("busy_hresp", resp, 1'b0); chk("busy_memen", en, 1'b0);
      @(posedge HCLK); #1;
    end
    HSELEXT = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    @(posedge HCLK); #1;

    // RD_LAT=2: INCR4 pipelined reads, then write/read of word 5.
    inst = 1'b1;
    issue(34'h00, 0, 3'd3, HTRANS_NONSEQ, 3'b011, 64'h0, 8'h00, 0, 64'hCAFE000000000000, 2, 20'h0);
    issue(34'h08, 0, 3'd3, HTRANS_SEQ,    3'b011, 64'h0, 8'h00, 0, 64'hCAFE000000000001, 2, 20'h1);
    issue(34'h10, 0, 3'd3, HTRANS_SEQ,    3'b011, 64'h0, 8'h00, 0, 64'hCAFE000000000002, 2, 20'h2);
    issue(34'h18, 0, 3'd3, HTRANS_SEQ,    3'b011, 64'h0, 8'h00, 0, 64'hCAFE000000000003, 2, 20'h3);
    issue(34'h28, 1, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h0123456789ABCDEF, 8'hFF, 0, 64'h0, 0, 20'h5);
    issue(34'h28, 0, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h0, 8'h00, 0, 64'h0123456789ABCDEF, 2, 20'h5);
    idle_wait();

    // Reset asserted in the first RD cycle.
    HSELEXT = 1'b1; HADDR = 34'h28; HWRITE = 1'b0; HSIZE = 3'd3; HTRANS = HTRANS_NONSEQ;
    @(posedge HCLK); #1;
    HSELEXT = 1'b0; HTRANS = HTRANS_IDLE;
    #1;
    chk("midrd_memen", en, 1'b1);
    HRESETn = 1'b0;
    #1;
    chk("midrd_rst_memen", en, 1'b0);
    chk("midrd_rst_hready", HREADY, 1'b1);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      chk("post_rst_hready", HREADY, 1'b1); chk("post_rst_memen", en, 1'b0);
      @(posedge HCLK); #1;
    end
    last_busy = 1'b0;
    issue(34'h28, 0, 3'd3, HTRANS_NONSEQ, 3'd0, 64'h0, 8'h00, 0, 64'h0123456789ABCDEF, 2, 20'h5);
    idle_wait();

    repeat (3) @(posedge HCLK);
    checks++;
    if (rspq.size() != 0 || memq.size() != 0) begin
      failures++;
      $display("FAIL leftover: rsp=%0d mem=%0d expected 0", rspq.size(), memq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
